// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter that lets NUM_CORES requesters share one
// synchronous-write / combinational-read data memory. Each transaction takes
// IDLE -> ACCESS -> RESP, so at most one completes every three cycles.
module mem_arbiter #(
  parameter int NUM_CORES = 4,
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_CORES-1:0]        core_req,
  input  logic [NUM_CORES-1:0]        core_we,
  input  logic [NUM_CORES*ADDR_W-1:0] core_addr,
  input  logic [NUM_CORES*DATA_W-1:0] core_wdata,
  output logic [NUM_CORES-1:0]        core_ack,
  output logic [DATA_W-1:0]           core_rdata,
  output logic                        mem_write,
  output logic                        mem_read,
  output logic [ADDR_W-1:0]           mem_address,
  output logic [DATA_W-1:0]           mem_data_in,
  input  logic [DATA_W-1:0]           mem_data_out
);

  localparam int GW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam logic [NUM_CORES-1:0] ONE_HOT0 = NUM_CORES'(1);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t          state;
  logic [GW-1:0]   last_grant;
  logic [GW-1:0]   winner;
  logic [GW-1:0]   pick;
  logic            pick_valid;
  int unsigned     scan;

  logic [ADDR_W-1:0] addr_arr  [NUM_CORES];
  logic [DATA_W-1:0] wdata_arr [NUM_CORES];

  // Unpack the flattened per-core buses so the winner can be indexed directly.
  for (genvar g = 0; g < NUM_CORES; g++) begin : g_unpack
    assign addr_arr[g]  = core_addr[g*ADDR_W +: ADDR_W];
    assign wdata_arr[g] = core_wdata[g*DATA_W +: DATA_W];
  end

  // Round-robin search starting just after the last granted core, with wrap.
  always_comb begin
    pick       = '0;
    pick_valid = 1'b0;
    scan       = 0;
    for (int unsigned i = 0; i < NUM_CORES; i++) begin
      scan = (32'(last_grant) + 32'd1 + i) % 32'(NUM_CORES);
      if (!pick_valid && core_req[GW'(scan)]) begin
        pick       = GW'(scan);
        pick_valid = 1'b1;
      end
    end
  end

  // Transaction FSM. The memory-port registers double as the latched request:
  // address/data hold after ACCESS, and mem_read marks a read during ACCESS.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      core_ack    <= '0;
      core_rdata  <= '0;
      mem_write   <= 1'b0;
      mem_read    <= 1'b0;
      mem_address <= '0;
      mem_data_in <= '0;
      last_grant  <= GW'(NUM_CORES - 1);
      winner      <= '0;
    end else begin
      case (state)
        IDLE: begin
          core_ack <= '0;
          if (pick_valid) begin
            winner      <= pick;
            mem_address <= addr_arr[pick];
            mem_data_in <= wdata_arr[pick];
            mem_write   <= core_we[pick];
            mem_read    <= ~core_we[pick];
            state       <= ACCESS;
          end
        end
        ACCESS: begin
          if (mem_read) core_rdata <= mem_data_out;
          mem_write <= 1'b0;
          mem_read  <= 1'b0;
          core_ack  <= ONE_HOT0 << winner;
          state     <= RESP;
        end
        RESP: begin
          core_ack   <= '0;
          last_grant <= winner;
          state      <= IDLE;
        end
        default: begin
          core_ack  <= '0;
          mem_write <= 1'b0;
          mem_read  <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
